// File: rtl/cb_doutb_map_pkg.sv
// Shared CB port-B direction encoding and beat descriptor, used by both the
// write mapper and the read-side doutb mapper.
package cb_doutb_map_pkg;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_POS  = 2'b01,
    DIR_NEG  = 2'b10,
    DIR_NEW  = 2'b11
  } dir_e;

  // NEW-mode half select carried on l_k_0
  localparam logic DIR_NEW_0 = 1'b0;
  localparam logic DIR_NEW_1 = 1'b1;

  localparam int RSA_DW_DEF = 16;

  typedef struct packed {
    logic en;
    dir_e sel;
    logic lk0;
  } align_t;

  function automatic logic beat_live(align_t a);
    return a.en && (a.sel != DIR_IDLE);
  endfunction

endpackage

// File: rtl/cb_doutb_map_if.sv
// CB port-B read side in, skewed RSA operand lanes out.
interface cb_doutb_map_if #(
  parameter int L      = 4,
  parameter int Y      = 4,
  parameter int RSA_DW = 16
);
  logic [1:0]          CB_doutb_sel;
  logic                l_k_0;
  logic                CB_rd_en;
  logic [L*RSA_DW-1:0] CB_doutb;
  logic [Y*RSA_DW-1:0] CB_B_data;
  logic [Y-1:0]        CB_B_valid;
  logic                busy;
  logic                burst_done;

  modport master (
    output CB_doutb_sel, l_k_0, CB_rd_en, CB_doutb,
    input  CB_B_data, CB_B_valid, busy, burst_done
  );

  modport slave (
    input  CB_doutb_sel, l_k_0, CB_rd_en, CB_doutb,
    output CB_B_data, CB_B_valid, busy, burst_done
  );
endinterface

// File: rtl/cb_doutb_map_lane_skew_delay.sv
// Per-lane skew: DEPTH-stage shift of {valid, data}; DEPTH = 0 is a wire.
module lane_skew_delay #(
  parameter int DEPTH  = 1,
  parameter int RSA_DW = 16
) (
  input  logic            clk,
  input  logic            sys_rst,
  input  logic [RSA_DW:0] i_d,
  output logic [RSA_DW:0] o_d,
  output logic            o_any_vld
);

  if (DEPTH == 0) begin : g_thru
    logic w_unused;
    assign w_unused  = clk ^ sys_rst;
    assign o_d       = i_d;
    assign o_any_vld = 1'b0;
  end else begin : g_sr
    logic [DEPTH-1:0][RSA_DW:0] r_sr;

    always_ff @(posedge clk) begin
      if (sys_rst) begin
        r_sr <= '0;
      end else begin
        r_sr[0] <= i_d;
        for (int k = 1; k < DEPTH; k++) r_sr[k] <= r_sr[k-1];
      end
    end

    assign o_d = r_sr[DEPTH-1];

    // valid sits in the MSB of each stage
    always_comb begin
      o_any_vld = 1'b0;
      for (int k = 0; k < DEPTH; k++) o_any_vld = o_any_vld | r_sr[k][RSA_DW];
    end
  end

endmodule

// File: rtl/cb_doutb_map.sv
// Read-side CB port-B mapper: aligns direction with BRAM latency, remaps the
// L read lanes onto the Y RSA rows and applies the per-row input skew.
module cb_doutb_map
  import cb_doutb_map_pkg::*;
#(
  parameter int X       = 4,
  parameter int Y       = 4,
  parameter int L       = 4,
  parameter int RSA_DW  = RSA_DW_DEF,
  parameter int ROW_LEN = 10,
  parameter int RD_LAT  = 2
) (
  input logic           clk,
  input logic           sys_rst,
  cb_doutb_map_if.slave bus
);

  localparam int CW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;

  align_t                   w_issue, w_al;
  align_t [RD_LAT-1:0]      r_align;
  logic [L-1:0][RSA_DW-1:0] w_cb;
  logic [Y-1:0][RSA_DW-1:0] w_map_d, r_map_d;
  logic                     w_live, r_map_v, r_map_en;
  logic [CW-1:0]            r_beat_cnt;
  logic [Y-1:0][RSA_DW:0]   w_lane;
  logic [Y-1:0][RSA_DW-1:0] w_out_d;
  logic [Y-1:0]             w_out_v, w_skew_busy;
  logic                     r_lane_v_q, w_busy, w_unused;

  assign w_issue = '{en: bus.CB_rd_en, sel: dir_e'(bus.CB_doutb_sel), lk0: bus.l_k_0};
  assign w_cb    = bus.CB_doutb;
  assign w_al    = r_align[RD_LAT-1];

  // Direction rides alongside the read so it meets its data at the map stage
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_align <= '0;
    end else begin
      r_align[0] <= w_issue;
      for (int k = 1; k < RD_LAT; k++) r_align[k] <= r_align[k-1];
    end
  end

  always_comb begin
    w_map_d = '0;
    w_live  = beat_live(w_al);
    if (w_live) begin
      case (w_al.sel)
        DIR_POS: for (int i = 0; i < Y; i++) w_map_d[i] = w_cb[i];
        DIR_NEG: for (int i = 0; i < Y; i++) w_map_d[i] = w_cb[L-1-i];
        DIR_NEW: begin
          if (w_al.lk0 == DIR_NEW_1) begin
            w_map_d[0] = w_cb[0];
            w_map_d[1] = w_cb[1];
          end else begin
            w_map_d[0] = w_cb[2];
            w_map_d[1] = w_cb[3];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_map_d    <= '0;
      r_map_v    <= 1'b0;
      r_map_en   <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      r_map_d  <= w_map_d;
      r_map_v  <= w_live;
      r_map_en <= w_al.en;
      // beat index within the current run; pins at ROW_LEN-1
      if (!w_al.en || !r_map_en)                r_beat_cnt <= '0;
      else if (r_beat_cnt != CW'(ROW_LEN - 1))  r_beat_cnt <= r_beat_cnt + CW'(1);
    end
  end

  for (genvar i = 0; i < Y; i++) begin : g_lane
    lane_skew_delay #(.DEPTH(i), .RSA_DW(RSA_DW)) u_skew (
      .clk       (clk),
      .sys_rst   (sys_rst),
      .i_d       ({r_map_v, r_map_d[i]}),
      .o_d       (w_lane[i]),
      .o_any_vld (w_skew_busy[i])
    );
    assign w_out_d[i] = w_lane[i][RSA_DW-1:0];
    assign w_out_v[i] = w_lane[i][RSA_DW];
  end

  always_ff @(posedge clk) begin
    if (sys_rst) r_lane_v_q <= 1'b0;
    else         r_lane_v_q <= w_out_v[Y-1];
  end

  always_comb begin
    w_busy = r_map_en | r_map_v | (|w_skew_busy);
    for (int k = 0; k < RD_LAT; k++) w_busy = w_busy | r_align[k].en;
  end

  assign bus.CB_B_data  = w_out_d;
  assign bus.CB_B_valid = w_out_v;
  assign bus.busy       = w_busy;
  assign bus.burst_done = r_lane_v_q & ~w_out_v[Y-1];

  assign w_unused = ^{r_beat_cnt, 1'(X)};

endmodule

// File: doc/cb_doutb_map.md
Name: cb_doutb_map

Overview:
- Read-side counterpart of the CB port-B write mapper.
- Takes L-lane words read from the covariance bank (CB) port B and re-maps them into the Y-lane operand input of the RSA systolic array.
- Uses the same direction encoding as the write side: IDLE/POS/NEG/NEW.
- Aligns the direction select with the BRAM read latency, then applies the per-row input skew the systolic array needs. It sits between CB port B and the RSA operand input.

Parameters:
X, 4, RSA column count (informational; not used in datapath)
Y, 4, RSA row count = number of output lanes; must equal L
L, 4, CB port-B lane count; NEW mode is defined for L = 4 only
RSA_DW, 16, lane data width in bits
ROW_LEN, 10, maximum beats per read burst; sizes the beat counter
RD_LAT, 2, CB port-B read latency in cycles (>= 1)

Ports:
clk  input  1  system clock
sys_rst  input  1  reset
CB_doutb_sel  input  2  direction for this beat, issued with the CB read address (00 IDLE, 01 POS, 10 NEG, 11 NEW)
l_k_0  input  1  NEW-mode half select, issued with the read address
CB_rd_en  input  1  a CB port-B read is issued this cycle
CB_doutb  input  L*RSA_DW  CB port-B read data, valid RD_LAT cycles after issue
CB_B_data  output  Y*RSA_DW  skewed operand lanes to the RSA
CB_B_valid  output  Y  per-lane valid, skewed with the data
busy  output  1  any beat is in flight in the align, map or skew stages
burst_done  output  1  one-cycle pulse when lane Y-1 emits the final beat of a burst

Behaviour:
- Clocking: one clock, clk. Reset sys_rst is synchronous and active-high. All state updates on the rising clk edge only.
- Reset values: every pipeline register, CB_B_data, CB_B_valid, busy, burst_done and the beat counter go to 0. Reset asserted mid-burst flushes all in-flight beats; nothing is emitted afterwards.
- Align stage: {CB_rd_en, CB_doutb_sel, l_k_0} pass through an RD_LAT-deep shift register. The entry leaving it is paired with the CB_doutb sampled at the same edge.
- Map (on the aligned beat; en=0 or sel=IDLE gives all lanes 0, valid 0):
  - POS: out lane i = CB lane i.
  - NEG: out lane i = CB lane L-1-i.
  - NEW with l_k_0=1: lanes 0,1 = CB lanes 0,1; lanes 2,3 = 0.
  - NEW with l_k_0=0: lanes 0,1 = CB lanes 2,3; lanes 2,3 = 0.
  - For every beat with en=1 and sel != IDLE, all Y valid bits are 1, including zero-filled NEW lanes.
- Skew: lane i passes through i extra register stages; valid travels with its data.
  - A beat issued at edge t appears on lane i after edge t+RD_LAT+i.
  - Lane 0 = map register.
  - A lane whose valid is 0 drives data 0.
- Back-to-back issues stream one beat per cycle with no bubbles. A direction change between beats takes effect per beat.
- Burst accounting:
  - A burst = maximal run of consecutive aligned beats with en=1.
  - The beat counter is sized for ROW_LEN and saturates at ROW_LEN-1; it never wraps.
  - burst_done pulses for one cycle in the cycle after lane Y-1 emits the beat that ended the run, i.e. when lane Y-1 valid goes 1->0.
  - Two bursts separated by one idle cycle give two pulses.
- busy = OR of every valid and en bit in the align, map and skew stages. It drops to 0 in the same cycle burst_done is asserted.
- Simultaneous issue on the cycle a previous burst drains: the new beats are unaffected. burst_done still fires for the old burst.
- No backpressure: the RSA consumes every beat.

Decomposition:
- Shared package (with the write mapper): DIR_IDLE/DIR_POS/DIR_NEG/DIR_NEW = 2'b00/01/10/11 and DIR_NEW_0/DIR_NEW_1, plus the RSA_DW default.
- One sub-module, lane_skew_delay: a parameterised DEPTH x (RSA_DW+1) shift register, instantiated once per lane with DEPTH = i.
- Mapping and align logic stay in the top level.

Test Plan:
- POS single beat: CB_doutb lanes {0x0004,0x0003,0x0002,0x0001} (lane3..0), issue at edge 0, RD_LAT=2 -> lane0=0x0001 after edge 2, lane1=0x0002 after edge 3, lane2=0x0003 after edge 4, lane3=0x0004 after edge 5. Each valid is high for exactly one cycle; burst_done pulses once after lane3.
- NEG and NEW: same data. NEG gives lane0..3 = 0x0004,0x0003,0x0002,0x0001. NEW with l_k_0=0 gives lane0=0x0003, lane1=0x0004, lanes2,3 = 0 with valid=1. NEW with l_k_0=1 gives lane0=0x0001, lane1=0x0002, lanes2,3 = 0.
- Streaming: 10 back-to-back POS beats with lane data = beat index -> each lane shows 0..9 with no gaps. One burst_done pulse; busy stays high throughout and drops with the pulse.
- IDLE/en=0 interleave: POS, IDLE, POS issued consecutively -> middle slot has all valids 0 and all data 0. Two burst_done pulses.
- Reset mid-burst: assert sys_rst one cycle after the 3rd of 6 beats is issued -> all outputs 0 from the next edge. No later valid, no burst_done; busy = 0.
- Reset values: hold sys_rst for 3 cycles with random inputs -> all outputs stay 0.
